// File: rtl/pll_clk_checker.sv
// PLL output frequency checker: waits for a stable lock, counts rising edges of
// meas_in over a fixed gate window and judges the count against [EXP_MIN, EXP_MAX].
module pll_clk_checker #(
    parameter int GATE_CYCLES   = 50000,
    parameter int SETTLE_CYCLES = 1000,
    parameter int CNT_W         = 16,
    parameter int EXP_MIN       = 95,
    parameter int EXP_MAX       = 105
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             locked,
    input  logic             meas_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             pass,
    output logic             lock_err,
    output logic             overflow
);

    localparam int GATE_W   = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] EXP_MIN_C = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0] EXP_MAX_C = CNT_W'(EXP_MAX);

    typedef enum logic [2:0] {IDLE, WAIT_LOCK, SETTLE, MEASURE, REPORT} state_t;

    logic lock_s1_q, lock_s2_q;
    logic meas_s1_q, meas_s2_q, meas_s3_q;
    logic lock_s, meas_edge;

    state_t              state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic [CNT_W-1:0]    edge_q, edge_d;
    logic                lerr_flag_q, lerr_flag_d;
    logic                ovf_flag_q, ovf_flag_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                pass_q, pass_d;
    logic                lock_err_q, lock_err_d;
    logic                overflow_q, overflow_d;

    // Both inputs are asynchronous to clk; the third meas stage only feeds edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_s1_q <= 1'b0;
            lock_s2_q <= 1'b0;
            meas_s1_q <= 1'b0;
            meas_s2_q <= 1'b0;
            meas_s3_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the old value of the previous one.
            lock_s1_q <= locked;
            lock_s2_q <= lock_s1_q;
            meas_s1_q <= meas_in;
            meas_s2_q <= meas_s1_q;
            meas_s3_q <= meas_s2_q;
        end
    end

    assign lock_s    = lock_s2_q;
    assign meas_edge = meas_s2_q & ~meas_s3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            gate_q      <= '0;
            edge_q      <= '0;
            lerr_flag_q <= 1'b0;
            ovf_flag_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            pass_q      <= 1'b0;
            lock_err_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            gate_q      <= gate_d;
            edge_q      <= edge_d;
            lerr_flag_q <= lerr_flag_d;
            ovf_flag_q  <= ovf_flag_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            count_q     <= count_d;
            pass_q      <= pass_d;
            lock_err_q  <= lock_err_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        // NOTE: every target gets a default here so no path leaves one unassigned (no latches).
        state_d     = state_q;
        settle_d    = settle_q;
        gate_d      = gate_q;
        edge_d      = edge_q;
        lerr_flag_d = lerr_flag_q;
        ovf_flag_d  = ovf_flag_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        count_d     = count_q;
        pass_d      = pass_q;
        lock_err_d  = lock_err_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = WAIT_LOCK;
                    busy_d     = 1'b1;
                    pass_d     = 1'b0;
                    lock_err_d = 1'b0;
                    overflow_d = 1'b0;
                    count_d    = '0;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_W'(SETTLE_CYCLES - 1);
                end
            end
            SETTLE: begin
                // Any lock glitch sends us back so the settle period restarts from full.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (settle_q == '0) begin
                    state_d     = MEASURE;
                    gate_d      = GATE_W'(GATE_CYCLES - 1);
                    edge_d      = '0;
                    lerr_flag_d = 1'b0;
                    ovf_flag_d  = 1'b0;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end
            MEASURE: begin
                if (!lock_s) begin
                    lerr_flag_d = 1'b1;
                    state_d     = REPORT;
                end else begin
                    if (meas_edge) begin
                        if (edge_q == CNT_MAX) ovf_flag_d = 1'b1;
                        else                   edge_d     = edge_q + CNT_W'(1);
                    end
                    if (gate_q == '0) state_d = REPORT;
                    else              gate_d  = gate_q - GATE_W'(1);
                end
            end
            REPORT: begin
                count_d    = edge_q;
                overflow_d = ovf_flag_q;
                lock_err_d = lerr_flag_q;
                pass_d     = !lerr_flag_q && !ovf_flag_q &&
                             (edge_q >= EXP_MIN_C) && (edge_q <= EXP_MAX_C);
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign pass     = pass_q;
    assign lock_err = lock_err_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_pll_clk_checker.sv
// Directed-plus-random bench for pll_clk_checker; expected counts come from
// gate length / input period arithmetic, not from the design's state machine.
module tb_pll_clk_checker;

    localparam int GATE   = 1000;
    localparam int SETTLE = 16;
    localparam int CNT_W  = 8;
    localparam int SAT_W  = 7;
    localparam int EMIN   = 95;
    localparam int EMAX   = 105;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic locked = 1'b1;
    logic meas_in = 1'b0;

    logic             busy, done, pass, lock_err, overflow;
    logic [CNT_W-1:0] count;
    logic             s_busy, s_done, s_pass, s_lock_err, s_overflow;
    logic [SAT_W-1:0] s_count;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int meas_period = 10;
    int meas_high = 5;

    pll_clk_checker #(
        .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W),
        .EXP_MIN(EMIN), .EXP_MAX(EMAX)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .locked(locked), .meas_in(meas_in),
        .busy(busy), .done(done), .count(count), .pass(pass),
        .lock_err(lock_err), .overflow(overflow)
    );

    // Narrow-counter copy: the only way to reach saturation with a legal input rate.
    pll_clk_checker #(
        .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(SAT_W),
        .EXP_MIN(EMIN), .EXP_MAX(EMAX)
    ) dut_sat (
        .clk(clk), .rst(rst), .start(start), .locked(locked), .meas_in(meas_in),
        .busy(s_busy), .done(s_done), .count(s_count), .pass(s_pass),
        .lock_err(s_lock_err), .overflow(s_overflow)
    );

    always #5 clk = ~clk;

    initial begin : meas_gen
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            ph = (ph + 1 >= meas_period) ? 0 : ph + 1;
            meas_in = (ph < meas_high);
        end
    end

    initial forever begin
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        tests++;
        assert (obs >= lo && obs <= hi) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Steps negedge by negedge until done or the budget runs out.
    task automatic wait_done(input string tag, input int max, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < max) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, " done seen"}, done, 1'b1);
        check({tag, " busy low at done"}, busy, 1'b0);
    endtask

    task automatic run_plain(input string tag, input int period, input int high,
                             output int cycles);
        meas_period = period;
        meas_high   = high;
        repeat ($urandom_range(3, 40)) @(negedge clk);
        pulse_start();
        check({tag, " busy after start"}, busy, 1'b1);
        wait_done(tag, 1200, cycles);
    endtask

    task automatic check_results(input string tag, input int period);
        int lo, hi, s_lo, s_hi;
        bit exp_pass, exp_sovf;
        lo   = GATE / period;
        hi   = (GATE + period - 1) / period;
        exp_pass = (lo >= EMIN) && (hi <= EMAX);
        exp_sovf = (lo > (1 << SAT_W) - 1);
        s_lo = exp_sovf ? (1 << SAT_W) - 1 : lo;
        s_hi = exp_sovf ? (1 << SAT_W) - 1 : hi;
        check_range({tag, " count"}, int'(count), lo, hi);
        check({tag, " pass"}, pass, exp_pass);
        check({tag, " lock_err"}, lock_err, 1'b0);
        check({tag, " overflow"}, overflow, 1'b0);
        check_range({tag, " sat count"}, int'(s_count), s_lo, s_hi);
        check({tag, " sat overflow"}, s_overflow, exp_sovf);
        check({tag, " sat pass"}, s_pass, exp_pass && !exp_sovf);
        @(negedge clk);
        check({tag, " done one cycle"}, done, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " done"}, done, 1'b0);
        check({tag, " count"}, count, 0);
        check({tag, " pass"}, pass, 1'b0);
        check({tag, " lock_err"}, lock_err, 1'b0);
        check({tag, " overflow"}, overflow, 1'b0);
    endtask

    initial begin : stimulus
        int cyc, snap;
        int periods [11] = '{5, 6, 7, 8, 9, 10, 11, 12, 14, 16, 20};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset sat busy", s_busy, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Lock already synchronized: 1 + SETTLE + GATE + 1 cycles from start sample to done.
        run_plain("t1 p10", 10, 5, cyc);
        check_range("t1 latency", cyc, 1016, 1022);
        check_results("t1 p10", 10);

        run_plain("t2 p8", 8, 4, cyc);
        check_results("t2 p8", 8);

        // Loss of lock around measure cycle 500.
        meas_period = 10;
        meas_high   = 3;
        pulse_start();
        repeat (517) @(negedge clk);
        locked = 1'b0;
        wait_done("t3", 6, cyc);
        check_range("t3 abort latency", cyc, 1, 4);
        check("t3 lock_err", lock_err, 1'b1);
        check("t3 pass", pass, 1'b0);
        check("t3 overflow", overflow, 1'b0);
        check_range("t3 count", int'(count), 48, 52);
        locked = 1'b1;
        repeat (5) @(negedge clk);

        // 250 edges: fits 8 bits, saturates the 7-bit copy.
        run_plain("t4 p4", 4, 2, cyc);
        check("t4 count", count, 250);
        check("t4 overflow", overflow, 1'b0);
        check("t4 pass", pass, 1'b0);
        check("t4 sat count", s_count, 127);
        check("t4 sat overflow", s_overflow, 1'b1);
        check("t4 sat pass", s_pass, 1'b0);
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            int p;
            p = periods[$urandom_range(0, 10)];
            run_plain($sformatf("rnd%0d p%0d", i, p), p, $urandom_range(2, p - 2), cyc);
            check_results($sformatf("rnd%0d p%0d", i, p), p);
        end

        // Late lock with a 3-cycle glitch inside the settle window.
        meas_period = 10;
        meas_high   = 5;
        locked      = 1'b0;
        snap        = done_cnt;
        pulse_start();
        check("t5 busy", busy, 1'b1);
        repeat (200) @(negedge clk);
        locked = 1'b1;
        repeat (10) @(negedge clk);
        locked = 1'b0;
        repeat (3) @(negedge clk);
        locked = 1'b1;
        wait_done("t5", 1200, cyc);
        check_range("t5 latency from relock", cyc, 1017, 1021);
        check_results("t5", 10);
        repeat (20) @(negedge clk);
        check("t5 single done", done_cnt - snap, 1);

        // Second start while busy must be ignored.
        snap = done_cnt;
        pulse_start();
        repeat (300) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t6a", 1200, cyc);
        check_results("t6a", 10);
        repeat (40) @(negedge clk);
        check("t6a single done", done_cnt - snap, 1);

        // Asynchronous reset clears held results.
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("t6 rst idle");
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset mid-measure: no done afterwards.
        pulse_start();
        repeat (600) @(negedge clk);
        check("t6b busy before rst", busy, 1'b1);
        snap = done_cnt;
        #2 rst = 1'b1;
        #1 check_all_zero("t6b rst measure");
        @(negedge clk);
        rst = 1'b0;
        repeat (1100) @(negedge clk);
        check("t6b no done after rst", done_cnt - snap, 0);
        check("t6b busy after rst", busy, 1'b0);

        run_plain("t6c p10", 10, 5, cyc);
        check_range("t6c latency", cyc, 1016, 1022);
        check_results("t6c p10", 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
